// File: rtl/dp_memory_param.sv
// Dual-port byte-enabled RAM with zero-fill after reset,
// configurable read latency and cross-port read-during-write behaviour.
module dp_memory_param #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 16,
  parameter int DEPTH         = 2**ADDR_W,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_ready,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_ready,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                init_busy,
  output logic                collision
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [IW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic [1:0]        req, we, inr, acc, wr, rd;
  logic [ADDR_W-1:0] addr  [2];
  logic [NB-1:0]     be    [2];
  logic [DATA_W-1:0] wd    [2];
  logic [DATA_W-1:0] old   [2];
  logic [DATA_W-1:0] wword [2];
  logic [DATA_W-1:0] rword [2];
  logic              same_wr;

  logic [1:0]        p1_v, nv, rv;
  logic [DATA_W-1:0] p1_d [2];
  logic [DATA_W-1:0] nd   [2];
  logic [DATA_W-1:0] rdat [2];

  assign ready     = (state == S_RUN);
  assign a_ready   = ready;
  assign b_ready   = ready;
  assign init_busy = (state == S_INIT);

  assign a_rdata  = rdat[0];
  assign b_rdata  = rdat[1];
  assign a_rvalid = rv[0];
  assign b_rvalid = rv[1];

  always_comb begin
    req  = {b_req, a_req};
    we   = {b_we, a_we};
    addr = '{a_addr, b_addr};
    be   = '{a_be, b_be};
    wd   = '{a_wdata, b_wdata};
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      inr[i] = int'(addr[i]) < DEPTH;
      acc[i] = req[i] && ready && rst_n;
      wr[i]  = acc[i] && we[i] && inr[i];
      rd[i]  = acc[i] && !we[i];
      old[i] = inr[i] ? mem[addr[i][IW-1:0]] : '0;
    end
  end

  assign same_wr = wr[0] && wr[1] && (addr[0] == addr[1]);

  // On a dual write A owns its enabled lanes, B fills lanes A left alone
  always_comb begin
    for (int l = 0; l < NB; l++) begin
      if (be[0][l])
        wword[0][l*8 +: 8] = wd[0][l*8 +: 8];
      else if (same_wr && be[1][l])
        wword[0][l*8 +: 8] = wd[1][l*8 +: 8];
      else
        wword[0][l*8 +: 8] = old[0][l*8 +: 8];
      wword[1][l*8 +: 8] = be[1][l] ? wd[1][l*8 +: 8]
                                    : old[1][l*8 +: 8];
    end
  end

  always_comb begin
    rword[0] = old[0];
    rword[1] = old[1];
    if (RDW_MODE != 0) begin
      if (wr[1] && addr[1] == addr[0])
        rword[0] = wword[1];
      if (wr[0] && addr[0] == addr[1])
        rword[1] = wword[0];
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else begin
      if (wr[0])
        mem[addr[0][IW-1:0]] <= wword[0];
      if (wr[1] && !same_wr)
        mem[addr[1][IW-1:0]] <= wword[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      cnt       <= '0;
      collision <= 1'b0;
    end else begin
      collision <= same_wr;
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IW'(DEPTH - 1))
          state <= S_RUN;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (RD_LATENCY == 1) begin
        nv[i] = rd[i];
        nd[i] = rword[i];
      end else begin
        nv[i] = p1_v[i];
        nd[i] = p1_d[i];
      end
    end
  end

  // Data is captured at acceptance, so later writes cannot disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= '0;
      rv   <= '0;
      p1_d <= '{default: '0};
      rdat <= '{default: '0};
    end else begin
      p1_v <= rd;
      rv   <= nv;
      for (int i = 0; i < 2; i++) begin
        if (rd[i])
          p1_d[i] <= rword[i];
        if (nv[i])
          rdat[i] <= nd[i];
      end
    end
  end

endmodule

// File: tb/tb_dp_memory_param.sv
// Scoreboard bench for dp_memory_param: latency-1/old-data and
// latency-2/new-data instances driven by identical stimulus.
module tb_dp_memory_param;

  typedef struct packed {
    logic [63:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [7:0]  a_be, b_be;
  logic [63:0] a_wdata, b_wdata;

  logic        a1_ready, b1_ready, a1_rvalid, b1_rvalid;
  logic        a2_ready, b2_ready, a2_rvalid, b2_rvalid;
  logic [63:0] a1_rdata, b1_rdata, a2_rdata, b2_rdata;
  logic        busy1, busy2, col1, col2;

  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  exp_t q [4][$];
  logic [63:0] last [4];
  logic        rv [4];
  logic [63:0] rdv [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dp_memory_param #(
    .DATA_W(64), .ADDR_W(4), .DEPTH(12),
    .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_be(a_be), .a_wdata(a_wdata),
    .a_ready(a1_ready), .a_rdata(a1_rdata), .a_rvalid(a1_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_be(b_be), .b_wdata(b_wdata),
    .b_ready(b1_ready), .b_rdata(b1_rdata), .b_rvalid(b1_rvalid),
    .init_busy(busy1), .collision(col1)
  );

  dp_memory_param #(
    .DATA_W(64), .ADDR_W(4), .DEPTH(12),
    .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_be(a_be), .a_wdata(a_wdata),
    .a_ready(a2_ready), .a_rdata(a2_rdata), .a_rvalid(a2_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_be(b_be), .b_wdata(b_wdata),
    .b_ready(b2_ready), .b_rdata(b2_rdata), .b_rvalid(b2_rvalid),
    .init_busy(busy2), .collision(col2)
  );

  always_comb begin
    rv[0]  = a1_rvalid;
    rv[1]  = b1_rvalid;
    rv[2]  = a2_rvalid;
    rv[3]  = b2_rvalid;
    rdv[0] = a1_rdata;
    rdv[1] = b1_rdata;
    rdv[2] = a2_rdata;
    rdv[3] = b2_rdata;
  end

  // Monitor: ports 0/1 = u1 A/B, ports 2/3 = u2 A/B
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        last[i] = '0;
      end else begin
        if (q[i].size() != 0 && q[i][0].due < cyc) begin
          e = q[i].pop_front();
          nchk++;
          nfail++;
          $display("FAIL rd%0d missing: no rvalid, required %h at cycle %0d",
                   i, e.d, e.due);
        end
        nchk++;
        if (rv[i]) begin
          if (q[i].size() == 0) begin
            nfail++;
            $display("FAIL rd%0d spurious: got rvalid rdata=%h, required none",
                     i, rdv[i]);
          end else begin
            e = q[i].pop_front();
            if (rdv[i] !== e.d || cyc != e.due) begin
              nfail++;
              $display("FAIL rd%0d data: got %h at cycle %0d, required %h at cycle %0d",
                       i, rdv[i], cyc, e.d, e.due);
            end
          end
          last[i] = rdv[i];
        end else if (rdv[i] !== last[i]) begin
          nfail++;
          $display("FAIL rd%0d hold: got %h, required %h", i, rdv[i], last[i]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", n, got, exp);
    end
  endtask

  task automatic ea(input logic [63:0] d1, input logic [63:0] d2);
    q[0].push_back('{d1, cyc + 1});
    q[2].push_back('{d2, cyc + 2});
  endtask

  task automatic eb(input logic [63:0] d1, input logic [63:0] d2);
    q[1].push_back('{d1, cyc + 1});
    q[3].push_back('{d2, cyc + 2});
  endtask

  task automatic op(
    input logic ar, input logic aw, input logic [3:0] aa,
    input logic [7:0] abe, input logic [63:0] ad,
    input logic br, input logic bw, input logic [3:0] ba,
    input logic [7:0] bbe, input logic [63:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_be = abe; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_be = bbe; b_wdata = bd;
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_init();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy1 && (a1_ready || b1_ready || a2_ready || b2_ready)) begin
        nfail++;
        $display("FAIL init_ready: got ready=1, required 0 at init cycle %0d", n);
      end
    end while ((busy1 || busy2) && n < 100);
    chk("init_len", 64'(n), 64'd12);
    chk("run_ready", {a1_ready, b1_ready, a2_ready, b2_ready}, 4'hf);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_be = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_be = 0; b_wdata = 0;
    idle(2);
    chk("rst_busy", {busy1, busy2}, 2'b11);
    chk("rst_ready", {a1_ready, b1_ready, a2_ready, b2_ready}, 4'h0);
    chk("rst_rvalid", {a1_rvalid, b1_rvalid, a2_rvalid, b2_rvalid}, 4'h0);
    chk("rst_rdata", a1_rdata | b1_rdata | a2_rdata | b2_rdata, 64'h0);
    chk("rst_col", {col1, col2}, 2'b00);
    rst_n = 1'b1;
    wait_init();

    for (int i = 0; i < 12; i++) begin
      ea(64'h0, 64'h0);
      eb(64'h0, 64'h0);
      op(1, 0, 4'(i), 8'h00, 64'h0, 1, 0, 4'(11 - i), 8'h00, 64'h0);
    end

    op(1, 1, 4'd1, 8'hff, 64'h0e0e0e0e0f0f0f0f, 0, 0, 0, 0, 0);
    ea(64'h0e0e0e0e0f0f0f0f, 64'h0e0e0e0e0f0f0f0f);
    op(1, 0, 4'd1, 8'h00, 64'h0, 0, 0, 0, 0, 0);

    op(1, 1, 4'd5, 8'h0f, 64'hffffffffffffffff, 0, 0, 0, 0, 0);
    ea(64'h00000000ffffffff, 64'h00000000ffffffff);
    op(1, 0, 4'd5, 8'h00, 64'h0, 0, 0, 0, 0, 0);

    op(0, 0, 0, 0, 0, 1, 1, 4'd7, 8'hff, 64'h0c0c);
    eb(64'h0c0c, 64'h00ff);
    op(1, 1, 4'd7, 8'hff, 64'h00ff, 1, 0, 4'd7, 8'h00, 64'h0);
    ea(64'h00ff, 64'h00ff);
    op(1, 0, 4'd7, 8'h00, 64'h0, 0, 0, 0, 0, 0);

    ea(64'h0, 64'h1234);
    op(1, 0, 4'd9, 8'h00, 64'h0, 1, 1, 4'd9, 8'h03, 64'hffff_ffff_ffff_1234);

    op(1, 1, 4'd3, 8'h01, 64'h11, 1, 1, 4'd3, 8'h03, 64'h2222);
    chk("col_pulse", {col1, col2}, 2'b11);
    idle(1);
    chk("col_clear", {col1, col2}, 2'b00);
    eb(64'h2211, 64'h2211);
    op(0, 0, 0, 0, 0, 1, 0, 4'd3, 8'h00, 64'h0);

    op(1, 1, 4'd13, 8'hff, 64'hdead, 1, 1, 4'd13, 8'hff, 64'hbeef);
    chk("col_oob", {col1, col2}, 2'b00);
    ea(64'h0, 64'h0);
    eb(64'h0, 64'h0);
    op(1, 0, 4'd13, 8'h00, 64'h0, 1, 0, 4'd12, 8'h00, 64'h0);
    ea(64'h0e0e0e0e0f0f0f0f, 64'h0e0e0e0e0f0f0f0f);
    op(1, 0, 4'd1, 8'h00, 64'h0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 1, 4'd1, 8'hff, 64'h0);
    ea(64'h0, 64'h0);
    op(1, 0, 4'd1, 8'h00, 64'h0, 0, 0, 0, 0, 0);
    idle(3);

    op(1, 1, 4'd5, 8'hff, 64'h5555, 0, 0, 0, 0, 0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    chk("midrd_busy", {busy1, busy2}, 2'b11);
    chk("midrd_rvalid", {a1_rvalid, a2_rvalid}, 2'b00);
    idle(2);
    rst_n = 1'b1;
    wait_init();
    ea(64'h0, 64'h0);
    op(1, 0, 4'd5, 8'h00, 64'h0, 0, 0, 0, 0, 0);
    idle(4);

    for (int i = 0; i < 4; i++)
      chk($sformatf("drain%0d", i), 64'(q[i].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dp_memory_param.md
DP_MEMORY_PARAM -- requirements
Module: dp_memory_param

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of words; may be less than 2**ADDR_W.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0, cross-port read-during-write result: 0 = old data, 1 = new data.
REQ-006 SHALL have parameter INIT_ON_RESET, default 1, zero-fill the array after reset.
REQ-007 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-009 SHALL have, per port p in {a,b}: p_req input 1 request; p_we input 1 write, else read; p_addr input ADDR_W; p_be input DATA_W/8 byte enables; p_wdata input DATA_W.
REQ-010 SHALL have, per port: p_ready output 1 request accepted; p_rdata output DATA_W read data; p_rvalid output 1 read-data strobe.
REQ-011 SHALL have port init_busy  output  1  zero-fill in progress.
REQ-012 SHALL have port collision  output  1  one-cycle pulse on a same-address dual write.

Function
REQ-013 SHALL implement FSM states INIT and RUN; p_ready = (state==RUN) on both ports.
REQ-014 INIT SHALL write zero to one address per cycle, counting 0..DEPTH-1, then enter RUN; init_busy is high throughout INIT, so INIT lasts exactly DEPTH cycles.
REQ-015 With INIT_ON_RESET=0 the FSM SHALL leave reset directly in RUN; init_busy stays 0.
REQ-016 A request SHALL be accepted on an edge where p_req && p_ready; a request made while p_ready=0 is ignored, not queued.
REQ-017 An accepted write SHALL update only the byte lanes with p_be=1 at the accepting edge; other lanes are unchanged; p_be is ignored for reads.
REQ-018 An accepted read SHALL drive p_rdata with p_rvalid=1 for exactly one cycle, RD_LATENCY cycles after the accepting edge.
REQ-019 p_rdata SHALL hold its last value until the next read completes; writes never assert p_rvalid.
REQ-020 Each port SHALL sustain one accepted read per cycle; ports are fully independent apart from REQ-021 and REQ-022.
REQ-021 Same address, A writes while B reads in the same cycle (and vice versa): RDW_MODE=0 SHALL return pre-write data; RDW_MODE=1 SHALL return byte-merged post-write data.
REQ-022 Both ports write the same address in the same cycle: lanes enabled on A take A data; lanes enabled only on B take B data; collision pulses high the following cycle.
REQ-023 An address >= DEPTH SHALL be handled as follows: a write is dropped; a read returns all-zero data with normal p_rvalid timing; collision never fires for it.
REQ-024 Writes issued in the same cycle as a read at RD_LATENCY=2 SHALL NOT alter data already captured in the read pipeline.

Reset
REQ-025 rst_n low SHALL asynchronously force p_rdata=0, p_rvalid=0, collision=0, flush both read pipelines, clear the INIT counter, and set state=INIT (RUN if INIT_ON_RESET=0).
REQ-026 init_busy SHALL equal INIT_ON_RESET during reset.
REQ-027 Reset asserted mid-INIT or mid-read SHALL restart INIT from address 0 and drop in-flight reads; array contents are undefined unless re-zeroed by INIT.

Verification (DATA_W=64, ADDR_W=4, DEPTH=12, INIT_ON_RESET=1)
REQ-028 Release rst_n -> init_busy=1 and p_ready=0 for 12 cycles, then RUN; reading addresses 0..11 returns 64'h0.
REQ-029 A writes 64'h0e0e0e0e0f0f0f0f at address 1 with be=8'hff; A then reads address 1 -> p_rdata=64'h0e0e0e0e0f0f0f0f with p_rvalid one cycle after acceptance (RD_LATENCY=1); repeat at RD_LATENCY=2 -> two cycles.
REQ-030 Address 5 holds 64'h0; A writes 64'hffffffffffffffff with be=8'h0f -> read returns 64'h00000000ffffffff.
REQ-031 Same cycle, A writes 64'h00ff at address 7 while B reads address 7 holding 64'h0c0c -> B gets 64'h0c0c with RDW_MODE=0 and 64'h00ff with RDW_MODE=1.
REQ-032 Same cycle, both ports write address 3: A data 64'h11 with be=8'h01, B data 64'h2222 with be=8'h03 -> stored value 64'h2211; collision=1 for one cycle.
REQ-033 Write to address 13 then read address 13 -> write has no effect and the read returns 64'h0 with p_rvalid; pulse rst_n low mid-read -> p_rvalid never fires and init_busy reasserts.
